// File: rtl/cmos_capture_rgb565.sv
// CMOS byte-stream capture: skips start-up frames, packs byte pairs into RGB565
// pixels and flags frames whose line/pixel geometry does not match the configured size.
module cmos_capture_rgb565 #(
    parameter logic        CMOS_VSYNC_VALID   = 1'b1,
    parameter logic [3:0]  CMOS_FRAME_WAITCNT = 4'd10,
    parameter logic [10:0] IMG_HDISP          = 11'd800,
    parameter logic [10:0] IMG_VDISP          = 11'd480
) (
    input  logic        cmos_pclk,
    input  logic        rst_n,
    input  logic        cmos_vsync,
    input  logic        cmos_href,
    input  logic [7:0]  cmos_data,
    output logic        cmos_init_done,
    output logic        cmos_frame_vsync,
    output logic        cmos_frame_href,
    output logic        cmos_frame_valid,
    output logic [15:0] cmos_frame_data,
    output logic        cmos_frame_err
);

    localparam logic [10:0] CNT_MAX = 11'h7FF;

    logic        vsync_q, href_q;
    logic [7:0]  data_q;
    logic        vld_q, vld_d1_q;
    logic        fv_d1_q, href_d1_q;
    logic        byte_flag_q, byte_flag_d;
    logic [7:0]  hi_byte_q, hi_byte_d;
    logic [10:0] pix_cnt_q, pix_cnt_d;
    logic [10:0] line_cnt_q, line_cnt_d;
    logic        pend_q, pend_d;
    logic [3:0]  frame_cnt_q, frame_cnt_d;
    logic        init_done_q, init_done_d;
    logic        out_en_q, out_en_d;
    logic        frame_vsync_q, frame_vsync_d;
    logic        frame_href_q, frame_href_d;
    logic        frame_valid_q, frame_valid_d;
    logic [15:0] frame_data_q, frame_data_d;
    logic        frame_err_q, frame_err_d;

    logic        fv;
    logic        frame_start, frame_end;
    logic        href_fall, pix_done, line_bad, en_now;
    logic [10:0] line_cnt_now;

    always_comb begin
        fv = CMOS_VSYNC_VALID ? vsync_q : ~vsync_q;
        // Frame edges need two real samples, so a frame already running at reset
        // release never looks like a fresh start but still ends normally.
        frame_start = vld_d1_q & fv & ~fv_d1_q;
        frame_end   = vld_d1_q & ~fv & fv_d1_q;
        href_fall   = href_d1_q & ~href_q;
        pix_done    = href_q & byte_flag_q;
        line_bad    = href_fall & ((pix_cnt_q != IMG_HDISP) | byte_flag_q);
        en_now      = out_en_q | (frame_start & init_done_q);

        line_cnt_now = line_cnt_q;
        if (href_fall && line_cnt_q != CNT_MAX) begin
            line_cnt_now = line_cnt_q + 11'd1;
        end

        byte_flag_d = href_q ? ~byte_flag_q : 1'b0;
        hi_byte_d   = (href_q & ~byte_flag_q) ? data_q : hi_byte_q;

        pix_cnt_d = pix_cnt_q;
        if (href_fall) begin
            pix_cnt_d = '0;
        end else if (pix_done && pix_cnt_q != CNT_MAX) begin
            pix_cnt_d = pix_cnt_q + 11'd1;
        end

        line_cnt_d = frame_start ? 11'd0 : line_cnt_now;
        pend_d     = frame_end ? 1'b0 : (pend_q | line_bad);

        frame_err_d = frame_err_q;
        if (frame_end) begin
            frame_err_d = pend_q | line_bad | (line_cnt_now != IMG_VDISP);
        end

        frame_cnt_d = frame_cnt_q;
        if (frame_end && frame_cnt_q < CMOS_FRAME_WAITCNT) begin
            frame_cnt_d = frame_cnt_q + 4'd1;
        end
        init_done_d = init_done_q | (frame_cnt_d == CMOS_FRAME_WAITCNT);
        out_en_d    = en_now;

        frame_vsync_d = en_now & fv;
        frame_href_d  = en_now & href_q;
        frame_valid_d = en_now & pix_done;
        frame_data_d  = (en_now & pix_done) ? {hi_byte_q, data_q} : frame_data_q;
    end

    always_ff @(posedge cmos_pclk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q       <= 1'b0;
            href_q        <= 1'b0;
            data_q        <= '0;
            vld_q         <= 1'b0;
            vld_d1_q      <= 1'b0;
            fv_d1_q       <= 1'b0;
            href_d1_q     <= 1'b0;
            byte_flag_q   <= 1'b0;
            hi_byte_q     <= '0;
            pix_cnt_q     <= '0;
            line_cnt_q    <= '0;
            pend_q        <= 1'b0;
            frame_cnt_q   <= '0;
            init_done_q   <= 1'b0;
            out_en_q      <= 1'b0;
            frame_vsync_q <= 1'b0;
            frame_href_q  <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_data_q  <= '0;
            frame_err_q   <= 1'b0;
        end else begin
            vsync_q       <= cmos_vsync;
            href_q        <= cmos_href;
            data_q        <= cmos_data;
            vld_q         <= 1'b1;
            vld_d1_q      <= vld_q;
            fv_d1_q       <= fv;
            href_d1_q     <= href_q;
            byte_flag_q   <= byte_flag_d;
            hi_byte_q     <= hi_byte_d;
            pix_cnt_q     <= pix_cnt_d;
            line_cnt_q    <= line_cnt_d;
            pend_q        <= pend_d;
            frame_cnt_q   <= frame_cnt_d;
            init_done_q   <= init_done_d;
            out_en_q      <= out_en_d;
            frame_vsync_q <= frame_vsync_d;
            frame_href_q  <= frame_href_d;
            frame_valid_q <= frame_valid_d;
            frame_data_q  <= frame_data_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign cmos_init_done   = init_done_q;
    assign cmos_frame_vsync = frame_vsync_q;
    assign cmos_frame_href  = frame_href_q;
    assign cmos_frame_valid = frame_valid_q;
    assign cmos_frame_data  = frame_data_q;
    assign cmos_frame_err   = frame_err_q;

endmodule

// File: tb/tb_cmos_capture_rgb565.sv
// Bench for cmos_capture_rgb565: two instances (active-high and active-low vsync,
// different skip counts) share one camera stream and are checked against a frame-level model.
module tb_cmos_capture_rgb565;

    localparam int H = 8;
    localparam int V = 4;

    logic       cmos_pclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmos_vsync = 1'b0;
    logic       cmos_href = 1'b0;
    logic [7:0] cmos_data = 8'h00;
    logic       vs_inv;

    logic [1:0]       init_o, fv_o, hs_o, vld_o, err_o;
    logic [1:0][15:0] dat_o;

    assign vs_inv = ~cmos_vsync;

    always #5 cmos_pclk = ~cmos_pclk;

    cmos_capture_rgb565 #(
        .CMOS_VSYNC_VALID(1'b1), .CMOS_FRAME_WAITCNT(4'd2),
        .IMG_HDISP(11'd8), .IMG_VDISP(11'd4)
    ) u_dut0 (
        .cmos_pclk(cmos_pclk), .rst_n(rst_n), .cmos_vsync(cmos_vsync),
        .cmos_href(cmos_href), .cmos_data(cmos_data),
        .cmos_init_done(init_o[0]), .cmos_frame_vsync(fv_o[0]), .cmos_frame_href(hs_o[0]),
        .cmos_frame_valid(vld_o[0]), .cmos_frame_data(dat_o[0]), .cmos_frame_err(err_o[0])
    );

    cmos_capture_rgb565 #(
        .CMOS_VSYNC_VALID(1'b0), .CMOS_FRAME_WAITCNT(4'd1),
        .IMG_HDISP(11'd8), .IMG_VDISP(11'd4)
    ) u_dut1 (
        .cmos_pclk(cmos_pclk), .rst_n(rst_n), .cmos_vsync(vs_inv),
        .cmos_href(cmos_href), .cmos_data(cmos_data),
        .cmos_init_done(init_o[1]), .cmos_frame_vsync(fv_o[1]), .cmos_frame_href(hs_o[1]),
        .cmos_frame_valid(vld_o[1]), .cmos_frame_data(dat_o[1]), .cmos_frame_err(err_o[1])
    );

    typedef struct {
        logic [15:0] pix;
        int          cyc;
    } pix_t;

    pix_t q0[$];
    pix_t q1[$];

    int          cyc = 0;
    int          n_chk = 0;
    int          n_bad = 0;
    bit          in_rst = 1'b1;
    bit          rst_req = 1'b0;
    bit          rel_req = 1'b0;
    int          wcnt[2] = '{2, 1};
    bit          out_en[2];
    int          frame_ends = 0;
    int          lines = 0;
    bit          bad = 1'b0;
    int          line_bytes = 0;
    logic [7:0]  hi = 8'h00;
    bit          prev_vs = 1'b0;
    bit          prev_hs = 1'b0;
    bit          err_exp = 1'b0;
    bit          hist_vs[2][8];
    bit          hist_hs[2][8];
    logic [15:0] exp_data[2];
    int          strobes[2];
    int          strobe_base[2];
    int          frame_pix[2];
    int          lens[8];
    bit          pack = 1'b0;
    bit          rand_data = 1'b0;
    logic [7:0]  byte_seq = 8'h00;
    logic [7:0]  pk[4] = '{8'h12, 8'h34, 8'h56, 8'h78};

    task automatic check_val(input string tag, input int idx, input logic [31:0] got,
                             input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d got=0x%0h exp=0x%0h t=%0t", tag, idx, got, exp, $time);
        end
    endtask

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic pix_t qfront(input int i);
        return (i == 0) ? q0[0] : q1[0];
    endfunction

    task automatic qpop(input int i);
        if (i == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endtask

    task automatic qpush(input int i, input logic [15:0] pix, input int c);
        pix_t e;
        e.pix = pix;
        e.cyc = c;
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic model_reset();
        frame_ends = 0;
        lines = 0;
        bad = 1'b0;
        line_bytes = 0;
        hi = 8'h00;
        err_exp = 1'b0;
        q0.delete();
        q1.delete();
        for (int i = 0; i < 2; i++) begin
            out_en[i] = 1'b0;
            exp_data[i] = 16'h0000;
            strobe_base[i] = strobes[i];
            frame_pix[i] = 0;
            for (int k = 0; k < 8; k++) begin
                hist_vs[i][k] = 1'b0;
                hist_hs[i][k] = 1'b0;
            end
        end
    endtask

    // Frame-level reference: what each instance should emit, derived from the stream alone.
    task automatic model_step(input bit vs, input bit hs, input logic [7:0] d);
        int c = cyc;
        if (in_rst) begin
            for (int i = 0; i < 2; i++) begin
                hist_vs[i][c % 8] = 1'b0;
                hist_hs[i][c % 8] = 1'b0;
            end
            prev_vs = vs;
            return;
        end
        if (vs && !prev_vs) begin
            lines = 0;
            bad = 1'b0;
            for (int i = 0; i < 2; i++) begin
                if (frame_ends >= wcnt[i]) out_en[i] = 1'b1;
                strobe_base[i] = strobes[i];
                frame_pix[i] = 0;
            end
        end
        if (hs) begin
            if (line_bytes % 2 == 0) begin
                hi = d;
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (out_en[i]) begin
                        qpush(i, {hi, d}, c + 2);
                        frame_pix[i]++;
                    end
                end
            end
            line_bytes++;
        end else if (prev_hs) begin
            lines++;
            if (line_bytes != 2 * H) bad = 1'b1;
            line_bytes = 0;
        end
        if (!vs && prev_vs) begin
            err_exp = bad || (lines != V);
            frame_ends++;
            bad = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            hist_vs[i][c % 8] = vs & out_en[i];
            hist_hs[i][c % 8] = hs & out_en[i];
        end
        prev_vs = vs;
        prev_hs = hs;
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            check_val(tag, i, {11'd0, init_o[i], fv_o[i], hs_o[i], vld_o[i], err_o[i], dat_o[i]}, 32'd0);
        end
    endtask

    task automatic drive(input bit vs, input bit hs, input logic [7:0] d);
        bit just_rst = 1'b0;
        @(negedge cmos_pclk);
        if (rst_req) begin
            rst_n = 1'b0;
            rst_req = 1'b0;
            in_rst = 1'b1;
            model_reset();
            just_rst = 1'b1;
        end
        if (rel_req) begin
            rst_n = 1'b1;
            rel_req = 1'b0;
            in_rst = 1'b0;
            prev_hs = 1'b0;
        end
        cmos_vsync = vs;
        cmos_href = hs;
        cmos_data = d;
        model_step(vs, hs, d);
        if (just_rst) begin
            #1;
            check_zero("rst_async");
        end
    endtask

    task automatic mon(input int i);
        pix_t e;
        int   hidx = (cyc + 6) % 8;
        check_val("frame_vsync", i, fv_o[i], hist_vs[i][hidx]);
        check_val("frame_href", i, hs_o[i], hist_hs[i][hidx]);
        if (vld_o[i]) begin
            strobes[i]++;
            if (qsize(i) == 0) begin
                check_val("strobe_unexp", i, vld_o[i], 0);
            end else begin
                e = qfront(i);
                qpop(i);
                check_val("pix_data", i, dat_o[i], e.pix);
                check_val("pix_cycle", i, cyc, e.cyc);
                exp_data[i] = e.pix;
            end
        end else if (qsize(i) > 0) begin
            e = qfront(i);
            if (e.cyc <= cyc) begin
                check_val("strobe_missing", i, vld_o[i], 1);
                qpop(i);
            end
        end
        check_val("data_hold", i, dat_o[i], exp_data[i]);
    endtask

    always @(posedge cmos_pclk) begin
        cyc = cyc + 1;
        #1;
        mon(0);
        mon(1);
    end

    task automatic send_frame(input int nl, input int rst_line, input int rst_byte);
        logic [7:0] d;
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
        for (int l = 0; l < nl; l++) begin
            for (int b = 0; b < lens[l]; b++) begin
                if (l == rst_line && b == rst_byte)     rst_req = 1'b1;
                if (l == rst_line && b == rst_byte + 3) rel_req = 1'b1;
                if (pack && l == 0 && b < 4) d = pk[b];
                else if (rand_data)          d = 8'($urandom);
                else begin
                    d = byte_seq;
                    byte_seq = byte_seq + 8'd1;
                end
                drive(1'b1, 1'b1, d);
            end
            repeat ($urandom_range(1, 3)) drive(1'b1, 1'b0, 8'h00);
        end
        repeat (8) drive(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 2; i++) begin
            check_val("init_done", i, init_o[i], (frame_ends >= wcnt[i]) ? 1 : 0);
            check_val("frame_err", i, err_o[i], err_exp);
            check_val("frame_strobes", i, strobes[i] - strobe_base[i], frame_pix[i]);
        end
    endtask

    task automatic default_lens();
        for (int k = 0; k < 8; k++) lens[k] = 2 * H;
    endtask

    initial begin
        int kind;
        int nl;
        default_lens();
        for (int i = 0; i < 2; i++) begin
            out_en[i] = 1'b0;
            exp_data[i] = 16'h0000;
            strobes[i] = 0;
            strobe_base[i] = 0;
            frame_pix[i] = 0;
            for (int k = 0; k < 8; k++) begin
                hist_vs[i][k] = 1'b0;
                hist_hs[i][k] = 1'b0;
            end
        end

        repeat (3) drive(1'b0, 1'b0, 8'h00);
        #1;
        check_zero("reset_state");
        rel_req = 1'b1;
        repeat (4) drive(1'b0, 1'b0, 8'h00);
        #1;
        check_zero("post_release");

        // Skip frames, then packing with known bytes on the first output frames.
        send_frame(V, -1, -1);
        pack = 1'b1;
        send_frame(V, -1, -1);
        send_frame(V, -1, -1);
        pack = 1'b0;
        rand_data = 1'b1;

        lens[1] = 2 * H - 1;
        send_frame(V, -1, -1);
        default_lens();
        send_frame(V, -1, -1);
        send_frame(V - 1, -1, -1);
        send_frame(V, -1, -1);

        for (int f = 0; f < 12; f++) begin
            default_lens();
            nl = V;
            kind = $urandom_range(0, 5);
            case (kind)
                3: lens[$urandom_range(0, V - 1)] = 2 * $urandom_range(1, 10) - 1;
                4: nl = $urandom_range(2, 5);
                5: lens[$urandom_range(0, V - 1)] = 2 * $urandom_range(5, 10);
                default: ;
            endcase
            send_frame(nl, -1, -1);
        end

        default_lens();
        send_frame(V, 1, 5);
        send_frame(V, -1, -1);
        send_frame(V, -1, -1);
        send_frame(V, -1, -1);

        repeat (4) drive(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 2; i++) check_val("queue_drain", i, qsize(i), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
